xbar_slave_arbiter: RTL and testbench
=====================================

Name: xbar_slave_arbiter

Overview:
Per-slave arbiter of the crossbar. Decodes which masters target this slave, grants exactly one master at a time by round-robin, and drives that master's connect_approved_from_crossbar. It muxes the granted master's request onto the slave port and routes ack/rdata back. A watchdog aborts transactions the slave never acknowledges.

Parameters:
NUM_MASTERS, 4, number of master ports (≥2)
SEL_W, 2, number of address MSBs used for slave select
SLAVE_ID, 0, value of addr[31:32-SEL_W] that selects this slave
TIMEOUT, 255, BUSY cycles without ack before abort (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_from_masters  in  NUM_MASTERS  per-master request
addr_from_masters  in  32*NUM_MASTERS  packed addresses, master i at [32i+31:32i]
wdata_from_masters  in  32*NUM_MASTERS  packed write data
cmd_from_masters  in  NUM_MASTERS  per-master cmd (1 write, 0 read)
ack_from_slave  in  1  slave completion strobe
rdata_from_slave  in  32  slave read data
connect_approved_to_masters  out  NUM_MASTERS  one-hot grant, registered
ack_to_masters  out  NUM_MASTERS  ack routed to granted master
rdata_to_masters  out  32*NUM_MASTERS  rdata routed to granted master, others 0
req_to_slave  out  1  granted master's req
addr_to_slave  out  32  granted master's addr
wdata_to_slave  out  32  granted master's wdata
cmd_to_slave  out  1  granted master's cmd
grant_idx  out  $clog2(NUM_MASTERS)  index of granted master, registered
timeout_err  out  1  one-cycle pulse on watchdog abort, registered

Behaviour:
- Reset, synchronous: state=IDLE, ptr=0, grant=0, grant_idx=0, wcnt=0, timeout_err=0. One edge with rst=1 clears everything regardless of state.
- valid[i] = req_from_masters[i] & (addr_i[31:32-SEL_W]==SLAVE_ID). Only valid masters compete.
- IDLE: if any valid, pick the first valid index scanning ptr, ptr+1, …, wrapping mod NUM_MASTERS. Register grant one-hot and grant_idx, clear wcnt, go BUSY. Grant is visible the cycle after the request is sampled, so latency is 1.
- BUSY: slave outputs = granted master's req/addr/wdata/cmd, muxed combinationally. ack_to_masters[g]=ack_from_slave and rdata_to_masters slot g=rdata_from_slave, both combinational. All other slots are 0.
- BUSY exit, evaluated in priority order:
  (a) ack_from_slave=1 ends the transaction, including ack together with a req drop.
  (b) granted req=0 means the master abandoned the transaction.
  (c) wcnt==TIMEOUT-1 with no ack: set timeout_err=1 for the next cycle.
  Otherwise wcnt increments.
- On any exit: ptr <= (g+1) mod NUM_MASTERS, grant cleared, next state IDLE.
- Minimum one IDLE cycle between grants. Back-to-back: ack at cycle t, new grant visible at t+2.
- IDLE: all slave outputs, ack and rdata are 0. ack_from_slave in IDLE is ignored.
- A decode change of the granted master while BUSY does not revoke the grant. Only ack, req drop, timeout or rst end it.
- connect_approved_to_masters is at most one-hot at all times.

Decomposition:
- Package xbar_pkg holds ADDR_W=32, DATA_W=32, CMD_READ=0, CMD_WRITE=1, and the IDLE/BUSY state encoding.
- Sub-module rr_picker: combinational round-robin picker. Inputs are the valid vector and ptr; outputs are the one-hot grant, the index and any_valid.

Test Plan:
- Single write: master 2 req=1, addr=0x0000_0010, wdata=0xDEADBEEF, cmd=1 at cycle 0. Expect connect_approved=4'b0100 and addr_to_slave=0x10 at cycle 1. Ack at cycle 3 gives ack_to_masters=4'b0100 in cycle 3, grant=0 at cycle 4 and ptr=3.
- Round-robin: all 4 masters hold req with decoding addresses, slave acks 1 cycle after each grant. Grant order is 0,1,2,3,0, with one IDLE cycle between grants.
- Decode filter: master 1 uses addr=0x4000_0000 (MSBs 01), master 3 uses addr=0x0000_0100. Only master 3 is granted; master 1 never sees connect_approved.
- Read routing: master 0 cmd=0, slave returns rdata=0xCAFE_F00D with ack. Slot 0 equals 0xCAFE_F00D that cycle; slots 1–3 are 0.
- Timeout: TIMEOUT=8, grant master 0, no ack. After 8 BUSY cycles timeout_err pulses for exactly 1 cycle, grant drops and ptr=1.
- Abandon then reset: master 1 drops req mid-BUSY, so grant clears next cycle with no ack. Then grant master 2 and assert rst for 1 cycle while BUSY. All outputs are 0 next cycle, and the next arbitration with all masters requesting picks master 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: bus widths, command encoding and the
// per-slave arbiter state encoding.
package xbar_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/xbar_slave_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first valid requester
// found when scanning ptr, ptr+1, ... wrapping around NUM_MASTERS.
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] valid,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant_oh,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   any_valid
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the closest valid candidate wins last.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        cand      = '0;
        any_valid = |valid;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
            if (valid[cand]) begin
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave crossbar arbiter: filters masters whose address selects this
// slave, grants one at a time round-robin, muxes the winner onto the slave
// port, routes ack/rdata back, and aborts transactions that never complete.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_W       = 2,
    parameter int SLAVE_ID    = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req_from_masters,
    input  logic [ADDR_W*NUM_MASTERS-1:0] addr_from_masters,
    input  logic [DATA_W*NUM_MASTERS-1:0] wdata_from_masters,
    input  logic [NUM_MASTERS-1:0]        cmd_from_masters,
    input  logic                          ack_from_slave,
    input  logic [DATA_W-1:0]             rdata_from_slave,
    output logic [NUM_MASTERS-1:0]        connect_approved_to_masters,
    output logic [NUM_MASTERS-1:0]        ack_to_masters,
    output logic [DATA_W*NUM_MASTERS-1:0] rdata_to_masters,
    output logic                          req_to_slave,
    output logic [ADDR_W-1:0]             addr_to_slave,
    output logic [DATA_W-1:0]             wdata_to_slave,
    output logic                          cmd_to_slave,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx,
    output logic                          timeout_err
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    arb_state_t              state;
    logic [IDX_W-1:0]        ptr;
    logic [WCNT_W-1:0]       wcnt;
    logic [NUM_MASTERS-1:0]  valid;
    logic [NUM_MASTERS-1:0]  pick_oh;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    last_wait;
    logic [IDX_W-1:0]        next_ptr;

    // A master competes only when it requests and its address MSBs select this slave.
    always_comb begin
        valid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            valid[i] = req_from_masters[i] &&
                (addr_from_masters[ADDR_W*i + ADDR_W-1 -: SEL_W] == SEL_W'(SLAVE_ID));
        end
    end

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .valid     (valid),
        .ptr       (ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // The grant register is cleared in IDLE, so an AND-OR mux yields zeros when nobody owns the slave.
    always_comb begin
        req_to_slave     = 1'b0;
        addr_to_slave    = '0;
        wdata_to_slave   = '0;
        cmd_to_slave     = CMD_READ;
        rdata_to_masters = '0;
        ack_to_masters   = connect_approved_to_masters & {NUM_MASTERS{ack_from_slave}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (connect_approved_to_masters[i]) begin
                req_to_slave   = req_from_masters[i];
                addr_to_slave  = addr_from_masters[ADDR_W*i +: ADDR_W];
                wdata_to_slave = wdata_from_masters[DATA_W*i +: DATA_W];
                cmd_to_slave   = cmd_from_masters[i];
                rdata_to_masters[DATA_W*i +: DATA_W] = rdata_from_slave;
            end
        end
    end

    assign last_wait = (wcnt == WCNT_W'(TIMEOUT - 1));
    assign next_ptr  = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Arbitration FSM: grant in IDLE, then leave BUSY on ack, abandon or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= IDLE;
            ptr                         <= '0;
            connect_approved_to_masters <= '0;
            grant_idx                   <= '0;
            wcnt                        <= '0;
            timeout_err                 <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        connect_approved_to_masters <= pick_oh;
                        grant_idx                   <= pick_idx;
                        wcnt                        <= '0;
                        state                       <= BUSY;
                    end
                end
                BUSY: begin
                    if (ack_from_slave || !req_to_slave || last_wait) begin
                        timeout_err                 <= !ack_from_slave && req_to_slave;
                        ptr                         <= next_ptr;
                        connect_approved_to_masters <= '0;
                        state                       <= IDLE;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: directed scenarios followed by random
// traffic, with every cycle predicted by a transaction-level model and
// checked through a scoreboard queue by an independent monitor.
module tb_xbar_slave_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_from_masters;
    logic [32*N-1:0] addr_from_masters;
    logic [32*N-1:0] wdata_from_masters;
    logic [N-1:0]    cmd_from_masters;
    logic            ack_from_slave;
    logic [31:0]     rdata_from_slave;
    logic [N-1:0]    connect_approved_to_masters;
    logic [N-1:0]    ack_to_masters;
    logic [32*N-1:0] rdata_to_masters;
    logic            req_to_slave;
    logic [31:0]     addr_to_slave;
    logic [31:0]     wdata_to_slave;
    logic            cmd_to_slave;
    logic [1:0]      grant_idx;
    logic            timeout_err;

    xbar_slave_arbiter #(
        .NUM_MASTERS (N),
        .SEL_W       (2),
        .SLAVE_ID    (0),
        .TIMEOUT     (TMO)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req_from_masters            (req_from_masters),
        .addr_from_masters           (addr_from_masters),
        .wdata_from_masters          (wdata_from_masters),
        .cmd_from_masters            (cmd_from_masters),
        .ack_from_slave              (ack_from_slave),
        .rdata_from_slave            (rdata_from_slave),
        .connect_approved_to_masters (connect_approved_to_masters),
        .ack_to_masters              (ack_to_masters),
        .rdata_to_masters            (rdata_to_masters),
        .req_to_slave                (req_to_slave),
        .addr_to_slave               (addr_to_slave),
        .wdata_to_slave              (wdata_to_slave),
        .cmd_to_slave                (cmd_to_slave),
        .grant_idx                   (grant_idx),
        .timeout_err                 (timeout_err)
    );

    always #5 clk = ~clk;

    // Staged stimulus, committed to the DUT one cycle at a time.
    logic        s_rst;
    logic [N-1:0] s_req, s_cmd;
    logic [31:0] s_addr [N];
    logic [31:0] s_wdata [N];
    logic        s_ack;
    logic [31:0] s_rdata;
    bit          auto_ack;

    // Reference model: who owns the slave, who is next in line, how long we've waited.
    int owner     = -1;
    int rr_next   = 0;
    int waited    = 0;
    bit tmo_exp   = 1'b0;
    bit idx_fresh = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]    grant;
        int              idx;
        bit              idx_chk;
        logic            tmo;
        logic            req;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic            cmd;
        logic [N-1:0]    ack;
        logic [32*N-1:0] rdata;
    } exp_t;

    exp_t sb [$];

    function automatic bit targetsUs(int m);
        return req_from_masters[m] && ((addr_from_masters[32*m +: 32] >> 30) == 0);
    endfunction

    // Advance the model over the clock edge just taken, using the inputs seen at that edge.
    task automatic modelStep();
        bit done;
        int m;
        done = 1'b0;
        if (rst) begin
            owner = -1; rr_next = 0; waited = 0; tmo_exp = 1'b0; idx_fresh = 1'b1;
            return;
        end
        tmo_exp = 1'b0;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                m = (rr_next + k) % N;
                if (targetsUs(m)) begin
                    owner = m; waited = 0; idx_fresh = 1'b0;
                    break;
                end
            end
        end else begin
            if (ack_from_slave) done = 1'b1;
            else if (!req_from_masters[owner]) done = 1'b1;
            else if (waited == TMO - 1) begin done = 1'b1; tmo_exp = 1'b1; end
            else waited++;
            if (done) begin
                rr_next = (owner + 1) % N;
                owner   = -1;
            end
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.grant = '0; e.req = 1'b0; e.addr = '0; e.wdata = '0; e.cmd = 1'b0;
        e.ack = '0; e.rdata = '0;
        e.tmo     = tmo_exp;
        e.idx_chk = (owner >= 0) || idx_fresh;
        e.idx     = (owner >= 0) ? owner : 0;
        if (owner >= 0) begin
            e.grant[owner] = 1'b1;
            e.req   = req_from_masters[owner];
            e.addr  = addr_from_masters[32*owner +: 32];
            e.wdata = wdata_from_masters[32*owner +: 32];
            e.cmd   = cmd_from_masters[owner];
            e.ack[owner] = ack_from_slave;
            e.rdata[32*owner +: 32] = rdata_from_slave;
        end
        sb.push_back(e);
    endtask

    // One cycle: take the edge, update the model, drive new inputs, queue the expectation.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        modelStep();
        if (auto_ack) s_ack = (owner >= 0) && (waited >= 1);
        rst              = s_rst;
        req_from_masters = s_req;
        cmd_from_masters = s_cmd;
        for (int i = 0; i < N; i++) begin
            addr_from_masters[32*i +: 32]  = s_addr[i];
            wdata_from_masters[32*i +: 32] = s_wdata[i];
        end
        ack_from_slave   = s_ack;
        rdata_from_slave = s_rdata;
        pushExpected();
    endtask

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("connect_approved", connect_approved_to_masters, e.grant);
        if (e.idx_chk) cmp("grant_idx", grant_idx, e.idx);
        cmp("timeout_err", timeout_err, e.tmo);
        cmp("req_to_slave", req_to_slave, e.req);
        cmp("addr_to_slave", addr_to_slave, e.addr);
        cmp("wdata_to_slave", wdata_to_slave, e.wdata);
        cmp("cmd_to_slave", cmd_to_slave, e.cmd);
        cmp("ack_to_masters", ack_to_masters, e.ack);
        cmp("rdata_to_masters", rdata_to_masters, e.rdata);
    endtask

    // Monitor: compare whatever the DUT shows mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    task automatic clearInputs();
        s_req = '0; s_cmd = '0; s_ack = 1'b0; s_rdata = '0; auto_ack = 1'b0; s_rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
    endtask

    task automatic doReset();
        s_rst = 1'b1;
        applyStimulus();
        s_rst = 1'b0;
    endtask

    task automatic randomCycle();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                s_req[i] = ~s_req[i];
                if (s_req[i]) begin
                    s_addr[i] = $urandom;
                    if ($urandom_range(0, 2) != 0) s_addr[i][31:30] = 2'b00;
                    s_wdata[i] = $urandom;
                    s_cmd[i]   = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                s_addr[i][31:30] = 2'($urandom_range(0, 3));
            end
        end
        s_ack   = ($urandom_range(0, 3) == 0);
        s_rdata = $urandom;
        s_rst   = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1; req_from_masters = '0; addr_from_masters = '0; wdata_from_masters = '0;
        cmd_from_masters = '0; ack_from_slave = 1'b0; rdata_from_slave = '0;
        clearInputs();
        s_rst = 1'b1;
        repeat (2) applyStimulus();
        s_rst = 1'b0;

        $display("[TB] single write from master 2");
        s_req = 4'b0100; s_addr[2] = 32'h0000_0010; s_wdata[2] = 32'hDEAD_BEEF; s_cmd = 4'b0100;
        repeat (3) applyStimulus();
        s_ack = 1'b1;
        applyStimulus();
        s_ack = 1'b0; s_req = '0;
        repeat (2) applyStimulus();
        s_req = 4'b1001; auto_ack = 1'b1;
        repeat (6) applyStimulus();

        $display("[TB] round-robin with all masters requesting");
        clearInputs(); doReset();
        s_req = 4'b1111; auto_ack = 1'b1;
        repeat (16) applyStimulus();

        $display("[TB] decode filter");
        clearInputs(); doReset();
        s_addr[1] = 32'h4000_0000; s_addr[3] = 32'h0000_0100; s_req = 4'b1010; auto_ack = 1'b1;
        repeat (10) applyStimulus();

        $display("[TB] read routing");
        clearInputs();
        s_req = 4'b0001; s_rdata = 32'hCAFE_F00D; auto_ack = 1'b1;
        repeat (6) applyStimulus();

        $display("[TB] watchdog timeout");
        clearInputs(); doReset();
        s_req = 4'b0001;
        repeat (14) applyStimulus();
        s_req = '0;
        repeat (2) applyStimulus();

        $display("[TB] abandon then reset while busy");
        clearInputs(); doReset();
        s_req = 4'b0010;
        repeat (3) applyStimulus();
        s_req = '0;
        repeat (2) applyStimulus();
        s_req = 4'b0100;
        repeat (3) applyStimulus();
        s_rst = 1'b1;
        applyStimulus();
        s_rst = 1'b0; s_req = 4'b1111; auto_ack = 1'b1;
        repeat (6) applyStimulus();

        $display("[TB] random traffic");
        clearInputs(); doReset();
        repeat (3000) begin
            randomCycle();
            applyStimulus();
        end
        s_rst = 1'b0; s_req = '0; s_ack = 1'b0;
        applyStimulus();

        @(posedge clk);
        @(negedge clk);
        #1;
        cmp("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
